ext_cap_chain_walker: RTL
=========================

// Module: ext_cap_chain_walker
// PURPOSE
//  Walks the PCIe extended capability list (config space 100h-FFFh) to find a target
//  capability ID (e.g. 0010h SR-IOV), following each header's Next Capability Offset.
//  Sits upstream of the extended-capability header registers (SR-IOV etc.), issuing
//  config dword reads and consuming header dwords {next[31:20], ver[19:16], id[15:0]}.
//  Reports found offset/version or a terminating error to firmware/enumeration logic.
// PARAMETERS
//  START_OFFSET    12'h100  first extended capability header address
//  MAX_HOPS        48       max headers visited before loop error (1..1023)
//  TIMEOUT_CYCLES  256      max cycles req may wait for ack (>=2)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous active-low reset
//  start          in   1   1-cycle pulse: begin walk (ignored while busy)
//  target_cap_id  in   16  capability ID searched; sampled on accepted start
//  cfg_rd_req     out  1   config read request, held until ack
//  cfg_rd_addr    out  12  dword-aligned read address ([1:0]=0), stable while req
//  cfg_rd_ack     in   1   read complete; cfg_rd_data valid this cycle
//  cfg_rd_data    in   32  header dword read
//  busy           out  1   walk in progress
//  done           out  1   1-cycle pulse: walk finished (any outcome)
//  found          out  1   target located (valid from done, held until next start)
//  found_offset   out  12  header address of target (0 if not found)
//  found_ver      out  4   capability version of target (0 if not found)
//  err_code       out  2   0 none, 1 bad pointer, 2 loop/hop limit, 3 timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, hop counter 0, timeout counter 0. Reset mid-walk
//   aborts immediately; no done pulse; a pending req is dropped.
//  FSM IDLE -> RD -> FIN -> IDLE.
//   IDLE: start=1 -> latch target, clear found/offset/ver/err, hops=0,
//         addr=START_OFFSET, busy=1; cfg_rd_req=1 next cycle (start T -> req T+1).
//   RD: req held, addr stable; timeout counter increments per cycle without ack.
//       ack at cycle A (data sampled at A), evaluated in priority order:
//        1 data==32'hFFFF_FFFF -> err 1, FIN
//        2 addr==START_OFFSET and data==0 -> no caps, not found, err 0, FIN
//        3 data[15:0]==target -> found=1, offset=addr, ver=data[19:16], FIN
//        4 nxt={data[31:22],2'b00}; nxt==0 -> end of list, not found, FIN
//        5 nxt<100h -> err 1, FIN
//        6 hops+1==MAX_HOPS -> err 2, FIN
//        7 else hops++, addr=nxt, timeout cleared, req stays high with new addr at A+1.
//       Req deasserts A+1 for outcomes 1-6. Timeout counter reaching TIMEOUT_CYCLES
//       with no ack -> req low, err 3, FIN.
//   FIN: done=1 for exactly one cycle, busy=0 in same cycle, results valid; -> IDLE.
//  Per hop latency: one header per ack; back-to-back reads possible (ack every cycle).
//  cfg_rd_data[1:0] of next field (bits 21:20) reserved, masked.
//  ack while req=0: ignored. start while busy or in FIN: ignored (no restart).
//  start coincident with reset release: ignored (reset dominates).
//  found/found_offset/found_ver/err_code hold until next accepted start.
// TESTING
//  1 chain 100h(id 0001,next 140h)->140h(id 0010,ver 1,next 0): target 0010 ->
//    reads 100h,140h; found=1 offset=140h ver=1 err=0; done 1 cycle after 2nd ack.
//  2 chain 100h->180h->0 no match, target 0010 -> found=0 offset=0 err=0, 2 reads.
//  3 100h reads 0000_0000 -> found=0 err=0 after one read; 100h reads FFFF_FFFF
//    -> err=1.
//  4 100h next=0F0h -> err=1; self-loop 100h->100h -> err=2 after MAX_HOPS reads.
//  5 ack withheld TIMEOUT_CYCLES -> req drops, err=3, done pulse; late ack ignored.
//  6 rst_n low mid-walk -> req/busy/done 0 async; start while busy has no effect.

Source files
------------

// File: rtl/ext_cap_chain_walker_if.sv
// Bundles the walker's control, result and config-read signals.
// The walker uses the master modport; the requester/config-space side uses slave.
interface ext_cap_chain_walker_if;
  logic        start;
  logic [15:0] target_cap_id;
  logic        cfg_rd_req;
  logic [11:0] cfg_rd_addr;
  logic        cfg_rd_ack;
  logic [31:0] cfg_rd_data;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] found_offset;
  logic [3:0]  found_ver;
  logic [1:0]  err_code;

  modport master (
    input  start, target_cap_id, cfg_rd_ack, cfg_rd_data,
    output cfg_rd_req, cfg_rd_addr, busy, done, found, found_offset, found_ver, err_code
  );

  modport slave (
    output start, target_cap_id, cfg_rd_ack, cfg_rd_data,
    input  cfg_rd_req, cfg_rd_addr, busy, done, found, found_offset, found_ver, err_code
  );
endinterface

// File: rtl/ext_cap_chain_walker.sv
// Walks the PCIe extended capability list starting at START_OFFSET, issuing one
// config dword read per header and following Next Capability Offset until the
// target ID is found, the list ends, or an error (bad pointer, hop limit, timeout)
// terminates the walk. Results hold until the next accepted start.
module ext_cap_chain_walker #(
  parameter logic [11:0] START_OFFSET   = 12'h100,
  parameter int          MAX_HOPS       = 48,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ext_cap_chain_walker_if.master bus
);

  localparam int HOP_W = (MAX_HOPS > 1) ? $clog2(MAX_HOPS) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_PTR = 2'd1;
  localparam logic [1:0] ERR_LOOP    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, RD, FIN} state_t;

  state_t             state;
  logic [15:0]        target;
  logic [HOP_W-1:0]   hops;
  logic [TMO_W-1:0]   tmo;

  // Header decode for the dword currently on cfg_rd_data
  logic [11:0] nxt;
  logic        end_walk;
  logic        step;
  logic        hit;
  logic [1:0]  end_err;

  // Evaluate the termination rules in priority order for this cycle's ack/timeout
  always_comb begin
    nxt      = bus.cfg_rd_data[31:20] & 12'hFFC;  // bits 21:20 are reserved
    end_walk = 1'b0;
    step     = 1'b0;
    hit      = 1'b0;
    end_err  = ERR_NONE;
    if (bus.cfg_rd_ack) begin
      if (bus.cfg_rd_data == 32'hFFFF_FFFF) begin
        end_walk = 1'b1;
        end_err  = ERR_BAD_PTR;
      end else if ((bus.cfg_rd_addr == START_OFFSET) && (bus.cfg_rd_data == 32'h0)) begin
        end_walk = 1'b1;                            // no extended capabilities at all
      end else if (bus.cfg_rd_data[15:0] == target) begin
        end_walk = 1'b1;
        hit      = 1'b1;
      end else if (nxt == 12'h000) begin
        end_walk = 1'b1;                            // end of list, target absent
      end else if (nxt < 12'h100) begin
        end_walk = 1'b1;
        end_err  = ERR_BAD_PTR;                     // pointer back into legacy space
      end else if (hops == HOP_W'(MAX_HOPS - 1)) begin
        end_walk = 1'b1;
        end_err  = ERR_LOOP;
      end else begin
        step = 1'b1;
      end
    end else if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      end_walk = 1'b1;
      end_err  = ERR_TIMEOUT;
    end
  end

  // Walk FSM with registered request and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      target           <= '0;
      hops             <= '0;
      tmo              <= '0;
      bus.cfg_rd_req   <= 1'b0;
      bus.cfg_rd_addr  <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.found        <= 1'b0;
      bus.found_offset <= '0;
      bus.found_ver    <= '0;
      bus.err_code     <= ERR_NONE;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            target           <= bus.target_cap_id;
            hops             <= '0;
            tmo              <= '0;
            bus.found        <= 1'b0;
            bus.found_offset <= '0;
            bus.found_ver    <= '0;
            bus.err_code     <= ERR_NONE;
            bus.cfg_rd_addr  <= START_OFFSET;
            bus.cfg_rd_req   <= 1'b1;
            bus.busy         <= 1'b1;
            state            <= RD;
          end
        end
        RD: begin
          if (step) begin
            // Follow the pointer; request stays high with the new address
            hops            <= hops + 1'b1;
            tmo             <= '0;
            bus.cfg_rd_addr <= nxt;
          end else if (end_walk) begin
            bus.cfg_rd_req <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            bus.err_code   <= end_err;
            if (hit) begin
              bus.found        <= 1'b1;
              bus.found_offset <= bus.cfg_rd_addr;
              bus.found_ver    <= bus.cfg_rd_data[19:16];
            end
            state <= FIN;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        FIN: begin
          // done was a single-cycle pulse; start arriving here is dropped
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
